// File: rtl/riscv_decode_if.sv
// Decode-stage bundle: instruction word in, registered decode fields and flags out.
interface riscv_decode_if;
  logic [31:0] instruction;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        is_add;
  logic        is_addi;
  logic        is_beq;
  logic        is_bne;
  logic        is_blt;
  logic        is_bge;
  logic        is_bltu;
  logic        is_bgeu;
  logic        incorrect;

  modport master (
    output instruction,
    input  rd, rs1, rs2, imm,
    input  is_add, is_addi, is_beq, is_bne, is_blt, is_bge, is_bltu, is_bgeu,
    input  incorrect
  );

  modport slave (
    input  instruction,
    output rd, rs1, rs2, imm,
    output is_add, is_addi, is_beq, is_bne, is_blt, is_bge, is_bltu, is_bgeu,
    output incorrect
  );
endinterface

// File: rtl/riscv_decode.sv
// Registered RV32I subset decoder (ADD, ADDI and the six conditional branches).
// Every output is a flop; exactly one flag or incorrect is set out of reset.
module riscv_decode (
  input  logic           clk,
  input  logic           rst,
  riscv_decode_if.slave  dec
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // flag bit positions: 0 add, 1 addi, 2 beq, 3 bne, 4 blt, 5 bge, 6 bltu, 7 bgeu
  function automatic logic [31:0] imm_i(input logic [31:0] i);
    return {{20{i[31]}}, i[31:20]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] i);
    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [6:0]  funct7_s;
  logic [7:0]  flags_s;
  logic [31:0] imm_s;
  logic        incorrect_s;

  logic [4:0]  rd_r;
  logic [4:0]  rs1_r;
  logic [4:0]  rs2_r;
  logic [31:0] imm_r;
  logic [7:0]  flags_r;
  logic        incorrect_r;

  assign opcode_s = dec.instruction[6:0];
  assign funct3_s = dec.instruction[14:12];
  assign funct7_s = dec.instruction[31:25];

  // Combinational decode of the current instruction word into flags and immediate.
  always_comb begin
    flags_s = 8'b0;
    imm_s   = 32'b0;
    case (opcode_s)
      OPC_OP: begin
        if ((funct3_s == 3'b000) && (funct7_s == 7'b0000000)) begin
          flags_s[0] = 1'b1;
        end else begin
          flags_s = 8'b0;
        end
      end
      OPC_OP_IMM: begin
        if (funct3_s == 3'b000) begin
          flags_s[1] = 1'b1;
          imm_s      = imm_i(dec.instruction);
        end else begin
          flags_s = 8'b0;
        end
      end
      OPC_BRANCH: begin
        case (funct3_s)
          3'b000:  flags_s[2] = 1'b1;
          3'b001:  flags_s[3] = 1'b1;
          3'b100:  flags_s[4] = 1'b1;
          3'b101:  flags_s[5] = 1'b1;
          3'b110:  flags_s[6] = 1'b1;
          3'b111:  flags_s[7] = 1'b1;
          default: flags_s    = 8'b0;
        endcase
        // Illegal branch funct3 must leave imm at zero.
        if (flags_s != 8'b0) begin
          imm_s = imm_b(dec.instruction);
        end else begin
          imm_s = 32'b0;
        end
      end
      default: begin
        flags_s = 8'b0;
        imm_s   = 32'b0;
      end
    endcase
    incorrect_s = (flags_s == 8'b0);
  end

  // Output register stage; reset wins over the decode on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_r        <= 5'b0;
      rs1_r       <= 5'b0;
      rs2_r       <= 5'b0;
      imm_r       <= 32'b0;
      flags_r     <= 8'b0;
      incorrect_r <= 1'b0;
    end else begin
      rd_r        <= dec.instruction[11:7];
      rs1_r       <= dec.instruction[19:15];
      rs2_r       <= dec.instruction[24:20];
      imm_r       <= imm_s;
      flags_r     <= flags_s;
      incorrect_r <= incorrect_s;
    end
  end

  assign dec.rd        = rd_r;
  assign dec.rs1       = rs1_r;
  assign dec.rs2       = rs2_r;
  assign dec.imm       = imm_r;
  assign dec.is_add    = flags_r[0];
  assign dec.is_addi   = flags_r[1];
  assign dec.is_beq    = flags_r[2];
  assign dec.is_bne    = flags_r[3];
  assign dec.is_blt    = flags_r[4];
  assign dec.is_bge    = flags_r[5];
  assign dec.is_bltu   = flags_r[6];
  assign dec.is_bgeu   = flags_r[7];
  assign dec.incorrect = incorrect_r;

endmodule

// File: tb/tb_riscv_decode.sv
// Self-checking bench for riscv_decode: directed vectors, then random words
// compared against a table-driven reference model.
module tb_riscv_decode;

  logic clk;
  logic rst;
  riscv_decode_if dec ();

  riscv_decode dut (
    .clk (clk),
    .rst (rst),
    .dec (dec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [7:0]  flags;
    logic        incorrect;
  } exp_t;

  int total = 0;
  int bad   = 0;

  // Supported mnemonics in flag order: opcode, funct3, and whether funct7 must be zero.
  logic [6:0] tbl_opc  [8] = '{7'h33, 7'h13, 7'h63, 7'h63, 7'h63, 7'h63, 7'h63, 7'h63};
  logic [2:0] tbl_f3   [8] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
  logic       tbl_f7z  [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  function automatic exp_t model(input logic [31:0] i);
    exp_t e;
    int   op;
    int   off;
    op = 8;
    for (int k = 0; k < 8; k++) begin
      if (i[6:0] == tbl_opc[k] && i[14:12] == tbl_f3[k] && (!tbl_f7z[k] || i[31:25] == 7'd0))
        op = k;
    end
    e.rd  = i[11:7];
    e.rs1 = i[19:15];
    e.rs2 = i[24:20];
    e.imm = 32'd0;
    if (op == 1) begin
      e.imm = 32'($signed(i) >>> 20);
    end else if (op >= 2 && op <= 7) begin
      off = int'(i[11:8]) * 2 + int'(i[30:25]) * 32 + int'(i[7]) * 2048 - (i[31] ? 4096 : 0);
      e.imm = 32'(off);
    end
    e.flags     = (op < 8) ? (8'd1 << op) : 8'd0;
    e.incorrect = (op == 8);
    return e;
  endfunction

  function automatic exp_t mk(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] imm, input logic [7:0] flags, input logic inc);
    exp_t e;
    e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.flags = flags; e.incorrect = inc;
    return e;
  endfunction

  task automatic step(input logic [31:0] instr, input logic r);
    dec.instruction = instr;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input exp_t e);
    exp_t obs;
    obs.rd        = dec.rd;
    obs.rs1       = dec.rs1;
    obs.rs2       = dec.rs2;
    obs.imm       = dec.imm;
    obs.flags     = {dec.is_bgeu, dec.is_bltu, dec.is_bge, dec.is_blt,
                     dec.is_bne, dec.is_beq, dec.is_addi, dec.is_add};
    obs.incorrect = dec.incorrect;
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s observed rd=%0d rs1=%0d rs2=%0d imm=%h flags=%b inc=%b expected rd=%0d rs1=%0d rs2=%0d imm=%h flags=%b inc=%b",
             tag, obs.rd, obs.rs1, obs.rs2, obs.imm, obs.flags, obs.incorrect,
             e.rd, e.rs1, e.rs2, e.imm, e.flags, e.incorrect);
    end
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] prev;
    exp_t zero;
    zero = mk(5'd0, 5'd0, 5'd0, 32'd0, 8'd0, 1'b0);
    rst = 1'b1;
    dec.instruction = 32'h007302B3;

    // reset held two edges, then first real decode
    step(32'h007302B3, 1'b1); check("reset_0", zero);
    step(32'h007302B3, 1'b1); check("reset_1", zero);
    step(32'h007302B3, 1'b0); check("add_after_reset", mk(5'd5, 5'd6, 5'd7, 32'd0, 8'h01, 1'b0));

    step(32'h02138313, 1'b0); check("addi", mk(5'd6, 5'd7, 5'd1, 32'h00000021, 8'h02, 1'b0));
    step(32'h007302B3, 1'b0); check("add", mk(5'd5, 5'd6, 5'd7, 32'd0, 8'h01, 1'b0));
    step(32'h00208463, 1'b0); check("beq", mk(5'd8, 5'd1, 5'd2, 32'd8, 8'h04, 1'b0));
    step(32'hFE419EE3, 1'b0); check("bne_neg", mk(5'd29, 5'd3, 5'd4, 32'hFFFFFFFC, 8'h08, 1'b0));

    for (int k = 0; k < 4; k++) begin
      w = 32'h00208463 | (32'(4 + k) << 12);
      step(w, 1'b0);
      check("branch_sweep", mk(5'd8, 5'd1, 5'd2, 32'd8, 8'h10 << k, 1'b0));
    end

    step(32'h407302B3, 1'b0); check("illegal_sub", mk(5'd5, 5'd6, 5'd7, 32'd0, 8'd0, 1'b1));
    step(32'h0020A463, 1'b0); check("illegal_br010", mk(5'd8, 5'd1, 5'd2, 32'd0, 8'd0, 1'b1));
    step(32'h0020B463, 1'b0); check("illegal_br011", mk(5'd8, 5'd1, 5'd2, 32'd0, 8'd0, 1'b1));
    step(32'h00001013, 1'b0); check("illegal_opimm_f3", mk(5'd0, 5'd0, 5'd0, 32'd0, 8'd0, 1'b1));
    step(32'h00000000, 1'b0); check("illegal_zero", mk(5'd0, 5'd0, 5'd0, 32'd0, 8'd0, 1'b1));
    step(32'hFFF00093, 1'b0); check("addi_neg", mk(5'd1, 5'd0, 5'd31, 32'hFFFFFFFF, 8'h02, 1'b0));

    // mid-stream reset discards the in-flight decode
    step(32'h00208463, 1'b1); check("midstream_reset", zero);
    step(32'h00208463, 1'b0); check("after_midstream", mk(5'd8, 5'd1, 5'd2, 32'd8, 8'h04, 1'b0));

    // back-to-back random words, biased toward supported opcodes
    prev = 32'h00208463;
    for (int n = 0; n < 400; n++) begin
      w = $urandom;
      case ($urandom_range(0, 4))
        0: w[6:0] = 7'h33;
        1: begin w[6:0] = 7'h33; w[31:25] = 7'd0; w[14:12] = 3'($urandom_range(0, 1)); end
        2: w[6:0] = 7'h13;
        3: w[6:0] = 7'h63;
        default: ;
      endcase
      // output must still reflect the previous word just before the edge
      @(negedge clk);
      check("hold_prev", model(prev));
      step(w, 1'b0);
      check("random", model(w));
      prev = w;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
